// File: rtl/perf_event_counter.sv
// Cycle/stall/flush/retired-instruction counters with coherent valid/ready snapshots.
// Halt detection (unchanged PC while running) is built only when PERF_HALT_DETECT_EN is defined.
module perf_event_counter #(
    parameter int CNT_W       = 32,
    parameter int HALT_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             flush_i,
    input  logic             wb_valid_i,
    input  logic [31:0]      pc_i,
    input  logic             snap_req_i,
    input  logic             snap_ready_i,
    output logic             snap_valid_o,
    output logic [CNT_W-1:0] snap_cycle_o,
    output logic [CNT_W-1:0] snap_stall_o,
    output logic [CNT_W-1:0] snap_flush_o,
    output logic [CNT_W-1:0] snap_retired_o,
    output logic [1:0]       state_o,
    output logic             halted_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    state_t state, state_nxt;
    logic   halt_hit;
    logic   counting;

    logic [CNT_W-1:0] cnt_cycle, cnt_stall, cnt_flush, cnt_retired;

    logic             vld_p1;
    logic [CNT_W-1:0] snap_cycle_p1, snap_stall_p1, snap_flush_p1, snap_retired_p1;
    logic             snap_load;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + 1'b1;
        return v;
    endfunction

`ifdef PERF_HALT_DETECT_EN
    localparam int RUN_W = $clog2(HALT_CYCLES + 1);

    logic [31:0]      prev_pc;
    logic [RUN_W-1:0] run_cnt, run_cnt_nxt;

    // A stall restarts the streak: a stalled core is waiting, not spinning in place.
    assign run_cnt_nxt = ((pc_i == prev_pc) && !stall_i) ? run_cnt + 1'b1 : '0;
    assign halt_hit    = (state == ST_RUN) && (run_cnt_nxt == RUN_W'(HALT_CYCLES));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_pc <= '0;
            run_cnt <= '0;
        end else begin
            prev_pc <= pc_i;
            run_cnt <= (state == ST_RUN) ? run_cnt_nxt : '0;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc_i;
    assign halt_hit  = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start_i) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (!start_i)
                        state_nxt = ST_IDLE;
                    else if (halt_hit)
                        state_nxt = ST_HALTED;
                end
                ST_HALTED: state_nxt = ST_HALTED;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    assign counting = (state == ST_RUN);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_cycle   <= '0;
            cnt_stall   <= '0;
            cnt_flush   <= '0;
            cnt_retired <= '0;
        end else if (counting) begin
            cnt_cycle   <= sat_inc(cnt_cycle, 1'b1);
            cnt_stall   <= sat_inc(cnt_stall, stall_i && !branch_i);
            cnt_flush   <= sat_inc(cnt_flush, flush_i);
            cnt_retired <= sat_inc(cnt_retired, wb_valid_i);
        end
    end

    // Snapshot stage: captures live counters as registered in the request cycle.
    assign snap_load = snap_req_i && (!vld_p1 || snap_ready_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1          <= 1'b0;
            snap_cycle_p1   <= '0;
            snap_stall_p1   <= '0;
            snap_flush_p1   <= '0;
            snap_retired_p1 <= '0;
        end else if (snap_load) begin
            vld_p1          <= 1'b1;
            snap_cycle_p1   <= cnt_cycle;
            snap_stall_p1   <= cnt_stall;
            snap_flush_p1   <= cnt_flush;
            snap_retired_p1 <= cnt_retired;
        end else if (vld_p1 && snap_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    assign snap_valid_o   = vld_p1;
    assign snap_cycle_o   = snap_cycle_p1;
    assign snap_stall_o   = snap_stall_p1;
    assign snap_flush_o   = snap_flush_p1;
    assign snap_retired_o = snap_retired_p1;
    assign state_o        = state;
    assign halted_o       = (state == ST_HALTED);

endmodule

// File: tb/tb_perf_event_counter.sv
// Bench for perf_event_counter: a 32-bit and a 4-bit instance share stimulus; snapshots are
// scoreboarded against a reference model. Halt expectations follow PERF_HALT_DETECT_EN.
module tb_perf_event_counter;

    localparam int HC = 4;
`ifdef PERF_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, clear, stall, branch, flush, wb_valid, snap_req, snap_ready;
    logic [31:0] pc;

    logic        s_valid, s_halted;
    logic [1:0]  s_state;
    logic [31:0] s_cyc, s_stl, s_fl, s_ret;
    logic        s4_valid, s4_halted;
    logic [1:0]  s4_state;
    logic [3:0]  s4_cyc, s4_stl, s4_fl, s4_ret;

    perf_event_counter #(.CNT_W(32), .HALT_CYCLES(HC)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .stall_i(stall),
        .branch_i(branch), .flush_i(flush), .wb_valid_i(wb_valid), .pc_i(pc),
        .snap_req_i(snap_req), .snap_ready_i(snap_ready), .snap_valid_o(s_valid),
        .snap_cycle_o(s_cyc), .snap_stall_o(s_stl), .snap_flush_o(s_fl),
        .snap_retired_o(s_ret), .state_o(s_state), .halted_o(s_halted)
    );

    perf_event_counter #(.CNT_W(4), .HALT_CYCLES(HC)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .stall_i(stall),
        .branch_i(branch), .flush_i(flush), .wb_valid_i(wb_valid), .pc_i(pc),
        .snap_req_i(snap_req), .snap_ready_i(snap_ready), .snap_valid_o(s4_valid),
        .snap_cycle_o(s4_cyc), .snap_stall_o(s4_stl), .snap_flush_o(s4_fl),
        .snap_retired_o(s4_ret), .state_o(s4_state), .halted_o(s4_halted)
    );

    typedef struct {
        longint cyc;
        longint stl;
        longint fl;
        longint ret;
    } snap_t;

    snap_t sq[$];
    int checks = 0;
    int failures = 0;

    // Reference model: true event counts, state, PC-repeat streak, snapshot pending flag.
    int          m_state;
    longint      m_cyc, m_stl, m_fl, m_ret;
    bit          m_pend;
    int          m_streak;
    logic [31:0] m_prev;

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        int nxt;
        int sn;
        if (rst) begin
            m_state = 0; m_cyc = 0; m_stl = 0; m_fl = 0; m_ret = 0;
            m_pend = 0; m_streak = 0; m_prev = '0;
            sq.delete();
        end else begin
            if (snap_req && (!m_pend || snap_ready)) begin
                sq.push_back('{m_cyc, m_stl, m_fl, m_ret});
                m_pend = 1;
            end else if (m_pend && snap_ready) begin
                m_pend = 0;
            end
            sn  = (m_state == 1 && pc == m_prev && !stall) ? m_streak + 1 : 0;
            nxt = m_state;
            if (clear) begin
                m_cyc = 0; m_stl = 0; m_fl = 0; m_ret = 0;
                nxt = 0;
            end else begin
                if (m_state == 1) begin
                    m_cyc++;
                    if (stall && !branch) m_stl++;
                    if (flush) m_fl++;
                    if (wb_valid) m_ret++;
                end
                if (m_state == 0 && start) nxt = 1;
                else if (m_state == 1 && !start) nxt = 0;
                else if (m_state == 1 && HALT_EN && sn == HC) nxt = 2;
            end
            m_streak = (m_state == 1 && nxt == 1) ? sn : 0;
            m_prev   = pc;
            m_state  = nxt;
        end
        @(posedge clk);
        #1;
        chk("state", s_state, m_state);
        chk("state_w4", s4_state, m_state);
        chk("halted", s_halted, (m_state == 2));
        chk("snap_valid", s_valid, m_pend);
    endtask

    task automatic drive(input bit st, input bit sl, input bit br, input bit fl, input bit wb,
                         input logic [31:0] p);
        start = st; stall = sl; branch = br; flush = fl; wb_valid = wb; pc = p;
        step();
    endtask

    task automatic idle_step();
        drive(0, 0, 0, 0, 0, pc + 32'd4);
    endtask

    task automatic clear_step();
        clear = 1;
        idle_step();
        clear = 0;
    endtask

    task automatic snap_read(output longint c, output longint s, output longint f,
                             output longint r, output longint c4);
        snap_req = 1; snap_ready = 0;
        idle_step();
        snap_req = 0;
        c = s_cyc; s = s_stl; f = s_fl; r = s_ret; c4 = s4_cyc;
        snap_ready = 1;
        idle_step();
        snap_ready = 0;
    endtask

    // Monitor: compares every presented snapshot with the scoreboard head, pops on acceptance.
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid_w4", s4_valid, s_valid);
            if (s_valid) begin
                if (sq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL snap_unexpected valid=1 queued=0");
                end else begin
                    chk("snap_cycle", s_cyc, sat(sq[0].cyc, 32));
                    chk("snap_stall", s_stl, sat(sq[0].stl, 32));
                    chk("snap_flush", s_fl, sat(sq[0].fl, 32));
                    chk("snap_retired", s_ret, sat(sq[0].ret, 32));
                    chk("snap_cycle_w4", s4_cyc, sat(sq[0].cyc, 4));
                    chk("snap_stall_w4", s4_stl, sat(sq[0].stl, 4));
                    chk("snap_flush_w4", s4_fl, sat(sq[0].fl, 4));
                    chk("snap_retired_w4", s4_ret, sat(sq[0].ret, 4));
                    if (snap_ready) void'(sq.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        longint c, s, f, r, c4, held, held_r;
        rst = 1; start = 0; clear = 0; stall = 0; branch = 0; flush = 0; wb_valid = 0;
        pc = '0; snap_req = 0; snap_ready = 0;
        step();
        step();
        chk("rst_state", s_state, 0);
        chk("rst_halted", s_halted, 0);
        chk("rst_valid", s_valid, 0);
        chk("rst_snap_cycle", s_cyc, 0);
        chk("rst_snap_stall", s_stl, 0);
        chk("rst_snap_flush", s_fl, 0);
        chk("rst_snap_retired", s_ret, 0);
        chk("rst_snap_cycle_w4", s4_cyc, 0);
        rst = 0;

        // Ten running cycles with stalls, one flush and seven retirements.
        for (int i = 0; i < 10; i++)
            drive(1, (i == 3 || i == 4), 0, (i == 6), (i >= 1 && i <= 7), pc + 32'd4);
        idle_step();
        snap_read(c, s, f, r, c4);
        chk("tp1_cycle", c, 10);
        chk("tp1_stall", s, 2);
        chk("tp1_flush", f, 1);
        chk("tp1_retired", r, 7);
        chk("tp1_cycle_w4", c4, 10);

        // Stalls under a branch are not counted.
        clear_step();
        for (int i = 0; i < 5; i++)
            drive(1, (i >= 1 && i <= 3), (i >= 1 && i <= 3), 0, 0, pc + 32'd4);
        idle_step();
        snap_read(c, s, f, r, c4);
        chk("tp2_cycle", c, 5);
        chk("tp2_stall", s, 0);

        // Saturation of the 4-bit instance.
        clear_step();
        for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 0, pc + 32'd4);
        idle_step();
        snap_read(c, s, f, r, c4);
        chk("tp3_cycle", c, 20);
        chk("tp3_cycle_w4", c4, 15);
        for (int i = 0; i < 6; i++) drive(1, 0, 0, 0, 0, pc + 32'd4);
        idle_step();
        snap_read(c, s, f, r, c4);
        chk("tp3_hold_w4", c4, 15);

        // PC held at 0x40.
        clear_step();
        drive(1, 0, 0, 0, 0, 32'h40);
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 1, 32'h40);
        chk("tp4_halted", s_halted, HALT_EN);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 1, 32'h40);
        snap_read(c, s, f, r, c4);
        chk("tp4_frozen_cycle", c, HALT_EN ? 4 : 7);
        clear_step();
        chk("tp4_clear_state", s_state, 0);
        snap_read(c, s, f, r, c4);
        chk("tp4_clear_cycle", c, 0);
        chk("tp4_clear_retired", r, 0);

        // A stall in the middle of repeated PCs restarts the streak.
        clear_step();
        drive(1, 0, 0, 0, 0, 32'h40);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 32'h40);
        drive(1, 1, 0, 0, 0, 32'h40);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 32'h40);
        chk("tp5_no_halt", s_halted, 0);
        idle_step();

        // Pending snapshot holds while counting continues; reload on accept+request.
        clear_step();
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 1, pc + 32'd4);
        snap_req = 1; snap_ready = 0;
        drive(1, 0, 0, 0, 1, pc + 32'd4);
        held = s_cyc; held_r = s_ret;
        chk("tp6_first_cycle", held, 2);
        for (int i = 0; i < 5; i++) begin
            snap_req = (i == 2);
            drive(1, 1, 0, 1, 1, pc + 32'd4);
            chk("tp6_hold_cycle", s_cyc, held);
            chk("tp6_hold_retired", s_ret, held_r);
        end
        snap_req = 1; snap_ready = 1;
        drive(1, 0, 0, 0, 1, pc + 32'd4);
        snap_req = 0; snap_ready = 0;
        chk("tp6_reload_valid", s_valid, 1);
        chk("tp6_reload_cycle", s_cyc, held + 6);
        snap_ready = 1;
        idle_step();
        snap_ready = 0;

        // Randomized traffic with occasional clear and reset.
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            clear      = ($urandom_range(0, 49) == 0);
            snap_req   = ($urandom_range(0, 3) == 0);
            snap_ready = $urandom_range(0, 1);
            drive(($urandom_range(0, 7) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 5) == 0) ? pc + 32'd4 : pc);
        end
        rst = 0; clear = 0; snap_req = 0; snap_ready = 1;
        for (int i = 0; i < 3; i++) idle_step();
        chk("drain_queue_empty", sq.size(), 0);
        chk("drain_valid_low", s_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
